// File: rtl/isp_agc.sv
// rtl/isp_agc.sv - frame-mean auto gain control for the digital-gain stage
// Measures each frame's mean pixel, then nudges a 4.4 gain toward target at the next frame start.
module isp_agc #(
   parameter int BITS   = 8,
   parameter int WIDTH  = 1280,
   parameter int HEIGHT = 960,
   parameter int HYST   = 4,
   parameter int BIG_TH = 32
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [BITS-1:0] target,
   input  logic [7:0]      manual_gain,
   input  logic            in_href,
   input  logic            in_vsync,
   input  logic [BITS-1:0] in_raw,
   output logic [7:0]      gain,
   output logic            gain_update,
   output logic [BITS-1:0] frame_mean,
   output logic            mean_valid
);

   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int SUM_W = BITS + $clog2(NPIX);
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam int R_W   = CNT_W + 1;
   localparam int DC_W  = $clog2(SUM_W + 1);
   localparam int EW    = BITS + 2;

   localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
   localparam logic [DC_W-1:0]  DIV_LAST = DC_W'(SUM_W);
   localparam logic [EW-1:0]    HYST_E   = EW'(HYST);
   localparam logic [EW-1:0]    BIG_E    = EW'(BIG_TH);

   typedef enum logic [2:0] {WAIT, ACC, DIV, ADJ, PEND} state_t;

   state_t             state_q, state_d;
   logic               vsync_q, rise, fall;
   logic [SUM_W-1:0]   sum, sum_shl;
   logic [CNT_W-1:0]   count;
   logic [R_W-1:0]     rem, trial, rem_nxt;
   logic               q_bit;
   logic [DC_W-1:0]    div_cnt;
   logic [7:0]         next_gain, adj_gain;
   logic               next_ok;
   logic [EW-1:0]      m_e, t_e;
   logic [9:0]         g_ext;
   logic               clr_acc, acc_en, div_start, div_step, adj_en, commit;

   assign rise = in_vsync & ~vsync_q;
   assign fall = ~in_vsync & vsync_q;

   always_ff @(posedge pclk) begin
      if (!rst_n) state_q <= WAIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      clr_acc   = 1'b0;
      acc_en    = 1'b0;
      div_start = 1'b0;
      div_step  = 1'b0;
      adj_en    = 1'b0;
      commit    = 1'b0;
      case (state_q)
         WAIT: if (rise) begin
            clr_acc = 1'b1;
            state_d = ACC;
         end
         ACC: begin
            if (fall) begin
               if (count == '0) state_d = WAIT;
               else begin
                  div_start = 1'b1;
                  state_d   = DIV;
               end
            end else if (in_href && count < NPIX_C) acc_en = 1'b1;
         end
         DIV: begin
            if (rise) begin
               clr_acc = 1'b1;
               state_d = ACC;
            end else begin
               div_step = 1'b1;
               if (div_cnt == DIV_LAST) state_d = ADJ;
            end
         end
         ADJ: begin
            clr_acc = rise;
            adj_en  = ~rise;
            state_d = rise ? ACC : PEND;
         end
         PEND: if (rise) begin
            clr_acc = 1'b1;
            commit  = enable & next_ok;
            state_d = ACC;
         end
         default: state_d = WAIT;
      endcase
   end

   // Restoring divide: the quotient bits shift into sum as the dividend shifts out.
   always_comb begin
      trial   = {rem[R_W-2:0], sum[SUM_W-1]};
      q_bit   = rem[R_W-1] | (trial >= {1'b0, count});
      rem_nxt = q_bit ? trial - {1'b0, count} : trial;
      sum_shl = {sum[SUM_W-2:0], q_bit};
   end

   always_comb begin
      m_e   = {2'b00, frame_mean};
      t_e   = {2'b00, target};
      g_ext = {2'b00, gain};
      if (m_e + HYST_E < t_e)
         g_ext = g_ext + ((t_e - m_e > BIG_E) ? 10'd4 : 10'd1);
      else if (m_e > t_e + HYST_E)
         g_ext = g_ext - ((m_e - t_e > BIG_E) ? 10'd4 : 10'd1);
      if (g_ext[9] || g_ext < 10'h010) adj_gain = 8'h10;
      else if (g_ext > 10'h0FF)        adj_gain = 8'hFF;
      else                             adj_gain = g_ext[7:0];
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         vsync_q     <= 1'b0;
         sum         <= '0;
         count       <= '0;
         rem         <= '0;
         div_cnt     <= '0;
         frame_mean  <= '0;
         mean_valid  <= 1'b0;
         next_gain   <= 8'h10;
         next_ok     <= 1'b0;
         gain        <= 8'h10;
         gain_update <= 1'b0;
      end else begin
         vsync_q    <= in_vsync;
         mean_valid <= 1'b0;
         if (clr_acc) begin
            sum   <= '0;
            count <= '0;
         end else if (acc_en) begin
            sum   <= sum + {{(SUM_W-BITS){1'b0}}, in_raw};
            count <= count + CNT_W'(1);
         end else if (div_step) begin
            // The first DIV cycle only primes the remainder; SUM_W steps follow.
            if (div_cnt == '0) rem <= '0;
            else begin
               sum <= sum_shl;
               rem <= rem_nxt;
               if (div_cnt == DIV_LAST) begin
                  frame_mean <= sum_shl[BITS-1:0];
                  mean_valid <= 1'b1;
               end
            end
            div_cnt <= div_cnt + DC_W'(1);
         end
         if (div_start) div_cnt <= '0;

         if (adj_en) begin
            next_gain <= adj_gain;
            next_ok   <= enable;
         end else if (!enable || commit) next_ok <= 1'b0;

         gain_update <= 1'b0;
         if (!enable) begin
            gain        <= manual_gain;
            gain_update <= (manual_gain != gain);
         end else if (commit) begin
            gain        <= next_gain;
            gain_update <= (next_gain != gain);
         end
      end
   end

endmodule

// File: tb/tb_isp_agc.sv
// tb/tb_isp_agc.sv - directed and randomized frame bench for isp_agc
// Reference model works per frame: integer mean of the first 8 pixels and a gain rule.
module tb_isp_agc;

   localparam int HYST   = 4;
   localparam int BIG_TH = 32;
   localparam int LAT    = 13;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] target = 8'd128;
   logic [7:0] manual_gain = 8'h10;
   logic       in_href = 1'b0;
   logic       in_vsync = 1'b0;
   logic [7:0] in_raw = 8'd0;
   logic [7:0] gain;
   logic       gain_update;
   logic [7:0] frame_mean;
   logic       mean_valid;

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int mv_cnt = 0, gu_cnt = 0, mv_cycle = -1;
   int model_gain = 16;
   int pend_valid = 0, pend_next = 16;
   int last_mean = 0;

   isp_agc #(.BITS(8), .WIDTH(4), .HEIGHT(2), .HYST(HYST), .BIG_TH(BIG_TH)) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(enable), .target(target),
      .manual_gain(manual_gain), .in_href(in_href), .in_vsync(in_vsync),
      .in_raw(in_raw), .gain(gain), .gain_update(gain_update),
      .frame_mean(frame_mean), .mean_valid(mean_valid)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge pclk);
      cycle++;
      if (mean_valid) begin
         mv_cnt++;
         mv_cycle = cycle;
      end
      if (gain_update) gu_cnt++;
   endtask

   function automatic int adjust(input int g, input int m, input int t);
      int d = t - m;
      if (d > HYST) g += (d > BIG_TH) ? 4 : 1;
      else if (-d > HYST) g -= (-d > BIG_TH) ? 4 : 1;
      if (g < 16) g = 16;
      if (g > 255) g = 255;
      return g;
   endfunction

   // One frame: rise, npix pixels (mode 0 constant, 1 random), fall, then blank low cycles.
   task automatic frame(input string tag, input int npix, input int mode, input int val, input int blank);
      int s = 0, n = 0, exp_gu = 0, gu0, mv0, fall_cyc, px;
      in_vsync = 1'b1;
      in_href  = 1'b0;
      if (pend_valid && enable) begin
         exp_gu     = (pend_next != model_gain);
         model_gain = pend_next;
      end
      pend_valid = 0;
      gu0 = gu_cnt;
      cyc();
      cyc();
      check({tag, ".gain"}, gain, model_gain);
      check({tag, ".gain_update"}, gu_cnt - gu0, exp_gu);
      for (int i = 0; i < npix; i++) begin
         px = (mode != 0) ? int'($urandom_range(0, 255)) : val;
         in_raw  = px[7:0];
         in_href = 1'b1;
         if (n < 8) begin
            s += px;
            n++;
         end
         cyc();
      end
      in_href = 1'b0;
      in_raw  = 8'd0;
      cyc();
      mv0 = mv_cnt;
      in_vsync = 1'b0;
      fall_cyc = cycle;
      repeat (blank) cyc();
      check({tag, ".mean_valid"}, mv_cnt - mv0, (n > 0 && blank >= LAT) ? 1 : 0);
      if (n > 0 && blank >= LAT) begin
         last_mean = s / n;
         check({tag, ".latency"}, mv_cycle - fall_cyc, LAT);
      end
      check({tag, ".frame_mean"}, frame_mean, last_mean);
      if (n > 0 && blank > LAT && enable) begin
         pend_valid = 1;
         pend_next  = adjust(model_gain, last_mean, target);
      end
   endtask

   task automatic set_manual(input string tag, input int val);
      int gu0 = gu_cnt;
      enable      = 1'b0;
      manual_gain = val[7:0];
      cyc();
      cyc();
      check({tag, ".gain"}, gain, val);
      check({tag, ".pulses"}, gu_cnt - gu0, (val != model_gain) ? 1 : 0);
      model_gain = val;
      pend_valid = 0;
   endtask

   initial begin
      int blanks[5] = '{5, 12, 13, 14, 20};
      int gu0;

      rst_n = 1'b0;
      cyc();
      cyc();
      check("rst.gain", gain, 16);
      check("rst.gain_update", gain_update, 0);
      check("rst.frame_mean", frame_mean, 0);
      check("rst.mean_valid", mean_valid, 0);
      rst_n = 1'b1;
      cyc();

      frame("v2", 8, 0, 130, 20);
      frame("v1", 8, 0, 64, 20);
      frame("v1c", 8, 0, 64, 20);
      check("v1.gain14", gain, 8'h14);

      frame("v4a", 0, 0, 0, 20);
      frame("v4b", 12, 0, 10, 20);
      frame("v5a", 8, 0, 64, 5);
      frame("v5b", 8, 0, 64, 20);
      frame("bnd13", 8, 0, 200, 13);
      frame("bnd14", 8, 0, 200, 14);
      frame("bndc", 8, 0, 128, 20);

      set_manual("v3m", 8'hFE);
      enable = 1'b1;
      frame("v3a", 8, 0, 0, 20);
      frame("v3b", 8, 0, 0, 20);
      check("v3.gainFF", gain, 8'hFF);
      frame("v3c", 8, 0, 255, 20);
      set_manual("v3n", 8'h10);
      enable = 1'b1;
      frame("v3d", 8, 0, 255, 20);
      frame("v3e", 8, 0, 100, 20);

      for (int f = 0; f < 10; f++) begin
         target = 8'($urandom_range(0, 255));
         frame("rnd", int'($urandom_range(0, 12)), 1, 0, blanks[$urandom_range(0, 4)]);
      end

      set_manual("v6m", 8'h14);
      enable = 1'b1;
      target = 8'd128;
      in_vsync = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < 3; i++) begin
         in_href = 1'b1;
         in_raw  = 8'd200;
         cyc();
      end
      in_href = 1'b0;
      rst_n = 1'b0;
      cyc();
      check("v6.gain", gain, 16);
      check("v6.gain_update", gain_update, 0);
      check("v6.frame_mean", frame_mean, 0);
      check("v6.mean_valid", mean_valid, 0);
      rst_n = 1'b1;
      model_gain = 16;
      pend_valid = 0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         in_href = 1'b1;
         in_raw  = 8'd50;
         cyc();
      end
      in_href = 1'b0;
      cyc();
      gu0 = mv_cnt;
      in_vsync = 1'b0;
      repeat (20) cyc();
      check("v6.partial_mv", mv_cnt - gu0, 1);
      check("v6.partial_mean", frame_mean, 50);
      last_mean = 50;
      set_manual("v6n", 8'h30);
      frame("v6f", 8, 0, 64, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/isp_agc.md
ISP_AGC -- requirements
Module: isp_agc

Interface
REQ-001 Parameter BITS, 8, raw pixel width.
REQ-002 Parameter WIDTH, 1280, active pixels per line.
REQ-003 Parameter HEIGHT, 960, active lines per frame.
REQ-004 Parameter HYST, 4, mean-error deadband in pixel codes.
REQ-005 Parameter BIG_TH, 32, error above which the large gain step is used.
REQ-006 pclk  input  1  pixel clock; all logic on rising edge; one clock only.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 enable  input  1  1 = closed-loop gain control; 0 = manual gain.
REQ-009 target  input  BITS  desired frame mean.
REQ-010 manual_gain  input  8  gain used when enable=0, 4.4 unsigned.
REQ-011 in_href  input  1  pixel valid, same stream as fed to the digital-gain stage output.
REQ-012 in_vsync  input  1  high for the whole frame, low in vertical blanking.
REQ-013 in_raw  input  BITS  raw pixel.
REQ-014 gain  output  8  4.4 gain for the digital-gain stage.
REQ-015 gain_update  output  1  one-cycle pulse when gain changes value.
REQ-016 frame_mean  output  BITS  mean of last completed frame.
REQ-017 mean_valid  output  1  one-cycle pulse when frame_mean is updated.

Function
REQ-018 The block SHALL register in_vsync into vsync_q; rise = in_vsync&!vsync_q, fall = !in_vsync&vsync_q.
REQ-019 The block SHALL use states WAIT, ACC, DIV, ADJ, PEND.
REQ-020 WAIT: on rise, clear sum and count, go to ACC; all other input is ignored.
REQ-021 ACC: each cycle with in_href=1, the block SHALL add in_raw to sum (width BITS+clog2(WIDTH*HEIGHT)) and increment count, but only while count < WIDTH*HEIGHT; excess pixels are ignored.
REQ-022 ACC on fall: if count=0, go to WAIT with no mean_valid; else go to DIV.
REQ-023 DIV: restoring divider, one quotient bit per cycle, exactly SUM_W cycles; quotient = floor(sum/count), low BITS bits kept.
REQ-024 At DIV completion, the block SHALL load frame_mean, pulse mean_valid for one cycle, and go to ADJ.
REQ-025 ADJ (one cycle): compute next from the current gain as follows:
- mean+HYST < target: next = gain + (target-mean > BIG_TH ? 4 : 1).
- mean > target+HYST: next = gain - (mean-target > BIG_TH ? 4 : 1).
- otherwise next = gain.
- Use 9-bit arithmetic, clamped to [8'h10, 8'hFF].
- Go to PEND.
REQ-026 PEND: on rise, commit gain <= next (only if enable=1), clear sum/count, go to ACC; gain changes only at a frame start.
REQ-027 A rise in DIV or ADJ SHALL abandon the computation: no commit, no mean_valid from the aborted divide, accumulators cleared, go to ACC.
REQ-028 gain_update SHALL pulse in the cycle after a commit, only if the gain value changed.
REQ-029 enable=0: gain <= manual_gain every cycle, and gain_update pulses on a value change; measurement and frame_mean continue; pending next is discarded (no commit).
REQ-030 enable 0->1: the loop SHALL start from the current gain (the last manual_gain).
REQ-031 Latency: mean_valid SHALL occur SUM_W+2 cycles after the fall is detected; vertical blanking of less than SUM_W+3 cycles yields no update (per REQ-027).

Reset
REQ-032 rst_n=0 at a pclk edge SHALL force state=WAIT, gain=8'h10, gain_update=0, frame_mean=0, mean_valid=0, sum=0, count=0, vsync_q=0, regardless of state.
REQ-033 After reset release mid-frame, vsync_q=0 and in_vsync=1 produce a rise on the first cycle; that partial frame is accumulated, and the result is valid-but-partial.

Verification
REQ-034 Use WIDTH=4, HEIGHT=2, BITS=8, enable=1, target=128 for the following scenarios:
- V1: 8 pixels of 64, then fall -> frame_mean=64, mean_valid pulse; next rise -> gain 8'h10->8'h14, gain_update pulse.
- V2: 8 pixels of 130 -> frame_mean=130, mean_valid pulse; gain stays 8'h10; no gain_update.
- V3: gain at 8'hFE, dark frame (raw=0) -> gain 8'hFF; repeat -> stays 8'hFF, no gain_update; bright frame at 8'h10 (raw=255) -> stays 8'h10.
- V4: frame with in_href never high -> no mean_valid, gain unchanged; 12 pixels of 10 in one frame -> only the first 8 counted, frame_mean=10.
- V5: rise 5 cycles after fall (inside DIV) -> no mean_valid, gain unchanged; the following frame of 64s -> V1 behaviour.
- V6: rst_n low for 1 cycle mid-ACC with gain=8'h14 -> gain=8'h10 and all outputs zero next cycle; enable=0, manual_gain=8'h30 -> gain=8'h30 with one gain_update pulse.
